updown_count_ctrl: RTL and testbench

Command-driven sequencer for an N-bit up/down counter. It accepts a run command (direction, start value, step count) over a valid/ready handshake, then steps an internal synchronous counter once per enabled clock. It supports pause and abort, and reports completion and wrap-around. It is the controller layer above the team's T-flip-flop up/down counters. Direction is latched per run, so it can never change mid-count.

---
 rtl/updown_count_ctrl.sv | 100 ++++++++++
 tb/tb_updown_count_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/updown_count_ctrl.sv
// Command-driven sequencer for an N-bit up/down counter.
// It accepts one run per handshake, then steps, pauses or aborts, and flags done and wrap.
module updown_count_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_dir_i,
    input  logic [N-1:0] cmd_start_i,
    input  logic [N-1:0] cmd_len_i,
    input  logic         pause_i,
    input  logic         abort_i,
    output logic [N-1:0] q_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         aborted_o,
    output logic         wrap_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [N-1:0] One  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] Zero = '0;
    localparam logic [N-1:0] Max  = '1;

    state_e       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] rem_q, rem_d;
    logic         dir_q, dir_d;
    logic         aborted_q, aborted_d;
    logic         wrap_q, wrap_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            q_q       <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b1;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
            wrap_q    <= wrap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        aborted_d = 1'b0;
        wrap_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    q_d     = cmd_start_i;
                    dir_d   = cmd_dir_i;
                    rem_d   = cmd_len_i;
                    state_d = (cmd_len_i != Zero) ? StRun : StDone;
                end
            end
            StRun: begin
                // Abort beats pause, and pause beats stepping.
                if (abort_i) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (!pause_i) begin
                    q_d    = dir_q ? (q_q + One) : (q_q - One);
                    wrap_d = dir_q ? (q_q == Max) : (q_q == Zero);
                    rem_d  = rem_q - One;
                    if (rem_q == One) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Gating with rst_i drops ready at once while reset is held.
    assign cmd_ready_o = (state_q == StIdle) && !rst_i;
    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);
    assign aborted_o   = aborted_q;
    assign wrap_o      = wrap_q;
    assign q_o         = q_q;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl: table of per-edge vectors plus a mid-run async reset.
module tb_updown_count_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [3:0] cmd_start;
    logic [3:0] cmd_len;
    logic       pause;
    logic       abort;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       wrap;

    int n_cmp;
    int n_bad;

    updown_count_ctrl #(.N(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_dir_i   (cmd_dir),
        .cmd_start_i (cmd_start),
        .cmd_len_i   (cmd_len),
        .pause_i     (pause),
        .abort_i     (abort),
        .q_o         (q),
        .busy_o      (busy),
        .done_o      (done),
        .aborted_o   (aborted),
        .wrap_o      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       d;
        logic [3:0] s;
        logic [3:0] l;
        logic       p;
        logic       a;
        logic [3:0] eq;
        logic       ebusy;
        logic       edone;
        logic       eabrt;
        logic       ewrap;
        logic       erdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic d, input int s, input int l,
                                input logic p, input logic a, input int eq, input logic ebusy,
                                input logic edone, input logic eabrt, input logic ewrap,
                                input logic erdy);
        vec_t r;
        r.v = v; r.d = d; r.s = 4'(s); r.l = 4'(l); r.p = p; r.a = a;
        r.eq = 4'(eq); r.ebusy = ebusy; r.edone = edone; r.eabrt = eabrt;
        r.ewrap = ewrap; r.erdy = erdy;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int eq, input logic ebusy,
                             input logic edone, input logic eabrt, input logic ewrap,
                             input logic erdy);
        check({tag, " q"}, int'(q), eq);
        check({tag, " busy"}, int'(busy), int'(ebusy));
        check({tag, " done"}, int'(done), int'(edone));
        check({tag, " aborted"}, int'(aborted), int'(eabrt));
        check({tag, " wrap"}, int'(wrap), int'(ewrap));
        check({tag, " cmd_ready"}, int'(cmd_ready), int'(erdy));
    endtask

    task automatic drive(input logic v, input logic d, input int s, input int l,
                         input logic p, input logic a);
        cmd_valid = v; cmd_dir = d; cmd_start = 4'(s); cmd_len = 4'(l);
        pause = p; abort = a;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

        //             v  d   s  l  p  a   q  bsy dn ab wr rdy
        // Up-run wrap 14 -> 1; abort in DONE and IDLE is ignored
        vecs.push_back(mk(1, 1, 14, 3, 0, 0, 14, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 15, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1, 1,  1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 1, 1,  1, 0, 0, 0, 0, 1));
        // Down-run wrap 2 -> 14
        vecs.push_back(mk(1, 0,  2, 4, 0, 0,  2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 15, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 14, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 14, 0, 0, 0, 0, 1));
        // Pause two cycles after edge 2; done lands on edge 8
        vecs.push_back(mk(1, 1,  5, 6, 0, 0,  5, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  6, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1, 0,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1, 0,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  8, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  9, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 11, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 11, 0, 0, 0, 0, 1));
        // Abort at edge 3 (abort beats pause)
        vecs.push_back(mk(1, 1,  5, 6, 0, 0,  5, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  6, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1, 1,  7, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  7, 0, 0, 0, 0, 1));
        // Zero length then back-to-back with cmd_valid held
        vecs.push_back(mk(1, 1,  9, 0, 0, 0,  9, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0,  9, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 15, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 15, 0, 0, 0, 0, 1));
        // Commands offered while busy are ignored
        vecs.push_back(mk(1, 1,  3, 3, 0, 0,  3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12, 5, 0, 0,  4, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  5, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 12, 5, 0, 0,  6, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,  6, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset held", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check_all("reset released", 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].d, int'(vecs[i].s), int'(vecs[i].l), vecs[i].p, vecs[i].a);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), int'(vecs[i].eq), vecs[i].ebusy, vecs[i].edone,
                      vecs[i].eabrt, vecs[i].ewrap, vecs[i].erdy);
        end

        // Async reset mid-run with q=11
        drive(1'b1, 1'b1, 8, 6, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all("pre-reset", 11, 1, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all("after reset", 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("post-reset%0d", k), 0, 0, 0, 0, 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
